reg_xfer_ctrl: RTL

REG_XFER_CTRL -- requirements
Module: reg_xfer_ctrl

---
 rtl/cpu6502_pkg.sv | 37 +++
 rtl/reg_xfer_ctrl_if.sv | 34 +++
 rtl/reg_xfer_decode.sv | 30 +++
 rtl/reg_xfer_ctrl.sv | 97 +++++++++
 4 files changed

// File: rtl/cpu6502_pkg.sv
// Shared 6502 register-transfer definitions: opcode values, controller state
// encoding and the decoded-opcode record passed from decoder to controller.
package cpu6502_pkg;

  localparam logic [7:0] OP_LDA_IMM = 8'hA9;
  localparam logic [7:0] OP_LDX_IMM = 8'hA2;
  localparam logic [7:0] OP_LDY_IMM = 8'hA0;
  localparam logic [7:0] OP_TAX     = 8'hAA;
  localparam logic [7:0] OP_TXA     = 8'h8A;
  localparam logic [7:0] OP_TAY     = 8'hA8;
  localparam logic [7:0] OP_TYA     = 8'h98;
  localparam logic [7:0] OP_INX     = 8'hE8;
  localparam logic [7:0] OP_DEX     = 8'hCA;
  localparam logic [7:0] OP_INY     = 8'hC8;
  localparam logic [7:0] OP_DEY     = 8'h88;
  localparam logic [7:0] OP_NOP     = 8'hEA;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_DECODE  = 2'd1,
    ST_OPERAND = 2'd2,
    ST_EXEC    = 2'd3
  } state_e;

  typedef enum logic [1:0] {CLS_ILLEGAL, CLS_IMM, CLS_IMPL} op_class_e;
  typedef enum logic [1:0] {DST_NONE, DST_A, DST_X, DST_Y} dest_e;
  typedef enum logic [1:0] {SRC_OPERAND, SRC_A, SRC_X, SRC_Y} src_e;
  typedef enum logic [1:0] {ALU_PASS, ALU_INC, ALU_DEC} alu_e;

  typedef struct packed {
    op_class_e cls;
    dest_e     dest;
    src_e      src;
    alu_e      alu;
  } op_decode_t;

endpackage

// File: rtl/reg_xfer_ctrl_if.sv
// Opcode handshake, operand fetch and register-file signals of the transfer
// controller; master is the CPU side offering opcodes, slave is the controller.
interface reg_xfer_ctrl_if;
  logic       op_valid;
  logic       op_ready;
  logic [7:0] opcode;
  logic [7:0] data_bus_in;
  logic       data_req;
  logic       data_valid;
  logic [7:0] acc_val;
  logic [7:0] x_val;
  logic [7:0] y_val;
  logic       acc_load;
  logic       x_load;
  logic       y_load;
  logic [7:0] reg_data_out;
  logic       flag_n;
  logic       flag_z;
  logic       flags_load;
  logic       done;
  logic       illegal_op;

  modport master (
    output op_valid, opcode, data_bus_in, data_valid, acc_val, x_val, y_val,
    input  op_ready, data_req, acc_load, x_load, y_load, reg_data_out,
           flag_n, flag_z, flags_load, done, illegal_op
  );

  modport slave (
    input  op_valid, opcode, data_bus_in, data_valid, acc_val, x_val, y_val,
    output op_ready, data_req, acc_load, x_load, y_load, reg_data_out,
           flag_n, flag_z, flags_load, done, illegal_op
  );
endinterface

// File: rtl/reg_xfer_decode.sv
// Combinational opcode classifier: addressing class, destination register,
// result source and increment/decrement selection.
module reg_xfer_decode
  import cpu6502_pkg::*;
(
  input  logic [7:0] opcode_i,
  output op_decode_t dec_o
);

  always_comb begin
    // NOTE: every field gets a default first so no path leaves a latch behind.
    dec_o = '{cls: CLS_ILLEGAL, dest: DST_NONE, src: SRC_OPERAND, alu: ALU_PASS};
    case (opcode_i)
      OP_LDA_IMM: dec_o = '{cls: CLS_IMM,  dest: DST_A,    src: SRC_OPERAND, alu: ALU_PASS};
      OP_LDX_IMM: dec_o = '{cls: CLS_IMM,  dest: DST_X,    src: SRC_OPERAND, alu: ALU_PASS};
      OP_LDY_IMM: dec_o = '{cls: CLS_IMM,  dest: DST_Y,    src: SRC_OPERAND, alu: ALU_PASS};
      OP_TAX:     dec_o = '{cls: CLS_IMPL, dest: DST_X,    src: SRC_A,       alu: ALU_PASS};
      OP_TAY:     dec_o = '{cls: CLS_IMPL, dest: DST_Y,    src: SRC_A,       alu: ALU_PASS};
      OP_TXA:     dec_o = '{cls: CLS_IMPL, dest: DST_A,    src: SRC_X,       alu: ALU_PASS};
      OP_TYA:     dec_o = '{cls: CLS_IMPL, dest: DST_A,    src: SRC_Y,       alu: ALU_PASS};
      OP_INX:     dec_o = '{cls: CLS_IMPL, dest: DST_X,    src: SRC_X,       alu: ALU_INC};
      OP_DEX:     dec_o = '{cls: CLS_IMPL, dest: DST_X,    src: SRC_X,       alu: ALU_DEC};
      OP_INY:     dec_o = '{cls: CLS_IMPL, dest: DST_Y,    src: SRC_Y,       alu: ALU_INC};
      OP_DEY:     dec_o = '{cls: CLS_IMPL, dest: DST_Y,    src: SRC_Y,       alu: ALU_DEC};
      OP_NOP:     dec_o = '{cls: CLS_IMPL, dest: DST_NONE, src: SRC_OPERAND, alu: ALU_PASS};
      default:    ;
    endcase
  end

endmodule

// File: rtl/reg_xfer_ctrl.sv
// 6502 register-transfer controller: accepts one opcode, fetches an immediate
// operand when needed, then issues a single-cycle register/flag write.
module reg_xfer_ctrl
  import cpu6502_pkg::*;
(
  input logic            clk_in,
  input logic            reset,
  reg_xfer_ctrl_if.slave bus
);

  state_e     state_q, state_d;
  logic [7:0] opcode_q, opcode_d;
  logic [7:0] operand_q, operand_d;
  op_decode_t dec;
  logic [7:0] src_val;
  logic [7:0] result;
  logic       exec_live;
  logic       wr_en;

  reg_xfer_decode u_decode (
    .opcode_i (opcode_q),
    .dec_o    (dec)
  );

  always_comb begin
    state_d   = state_q;
    opcode_d  = opcode_q;
    operand_d = operand_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.op_valid) begin
          opcode_d = bus.opcode;
          state_d  = ST_DECODE;
        end
      end
      ST_DECODE: begin
        case (dec.cls)
          CLS_IMM:  state_d = ST_OPERAND;
          CLS_IMPL: state_d = ST_EXEC;
          default:  state_d = ST_IDLE;
        endcase
      end
      ST_OPERAND: begin
        if (bus.data_valid) begin
          operand_d = bus.data_bus_in;
          state_d   = ST_EXEC;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments; reset is sampled on the clock edge only.
  always_ff @(posedge clk_in) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      opcode_q  <= 8'h00;
      operand_q <= 8'h00;
    end else begin
      state_q   <= state_d;
      opcode_q  <= opcode_d;
      operand_q <= operand_d;
    end
  end

  // Register sources are read live in EXEC so the result reflects current contents.
  always_comb begin
    case (dec.src)
      SRC_A:   src_val = bus.acc_val;
      SRC_X:   src_val = bus.x_val;
      SRC_Y:   src_val = bus.y_val;
      default: src_val = operand_q;
    endcase
    case (dec.alu)
      ALU_INC: result = src_val + 8'd1;
      ALU_DEC: result = src_val - 8'd1;
      default: result = src_val;
    endcase
  end

  // Strobes are gated by reset so an abort during EXEC or DECODE never writes.
  assign exec_live = (state_q == ST_EXEC) && reset;
  assign wr_en     = exec_live && (dec.dest != DST_NONE);

  assign bus.op_ready     = (state_q == ST_IDLE);
  assign bus.data_req     = (state_q == ST_OPERAND);
  assign bus.done         = exec_live;
  assign bus.illegal_op   = (state_q == ST_DECODE) && (dec.cls == CLS_ILLEGAL) && reset;
  assign bus.acc_load     = wr_en && (dec.dest == DST_A);
  assign bus.x_load       = wr_en && (dec.dest == DST_X);
  assign bus.y_load       = wr_en && (dec.dest == DST_Y);
  assign bus.flags_load   = wr_en;
  assign bus.reg_data_out = wr_en ? result : 8'h00;
  assign bus.flag_n       = wr_en && result[7];
  assign bus.flag_z       = wr_en && (result == 8'h00);

endmodule
